// File: rtl/parity_serial_rx_pkg.sv
// Shared types and constants for the parity serial receiver.
package parity_pkg;
   localparam int FRAME_BITS      = 9;
   localparam int DATA_BITS       = 8;
   localparam int DEFAULT_TIMEOUT = 64;

   typedef enum logic [2:0] {
      IDLE, SHIFT, PBIT, LAUNCH, WAIT_HI, WAIT_LO, CHECK, DONE
   } rx_state_t;
endpackage

// File: rtl/parity_serial_rx_if.sv
// Serial input, parity-checker handshake and frame result signals of the receiver.
interface parity_serial_rx_if;
   import parity_pkg::*;

   logic                 ser_in;
   logic                 ser_valid;
   logic                 ser_sof;
   logic                 chk_busy;
   logic                 chk_odd;
   logic                 chk_even;
   logic [DATA_BITS-1:0] chk_data;
   logic                 chk_start;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ok;
   logic                 rx_timeout;
   logic                 overrun;

   modport master (
      output ser_in, ser_valid, ser_sof, chk_busy, chk_odd, chk_even,
      input  chk_data, chk_start, rx_data, rx_valid, rx_ok, rx_timeout, overrun
   );

   modport slave (
      input  ser_in, ser_valid, ser_sof, chk_busy, chk_odd, chk_even,
      output chk_data, chk_start, rx_data, rx_valid, rx_ok, rx_timeout, overrun
   );
endinterface

// File: rtl/parity_serial_rx_shifter.sv
// LSB-first deserializer: data byte, bit counter and parity-bit capture.
module parity_rx_shifter
   import parity_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ser_in,
   input  logic                 load_first,
   input  logic                 shift_en,
   input  logic                 par_en,
   output logic [DATA_BITS-1:0] data,
   output logic                 par_bit,
   output logic                 last_bit
);
   localparam int CNT_W = $clog2(FRAME_BITS);
   localparam int IDX_W = $clog2(DATA_BITS);

   logic [CNT_W-1:0] bit_cnt;

   // A new start bit wipes any partial byte so a restarted frame never mixes old bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         data    <= '0;
         bit_cnt <= '0;
         par_bit <= 1'b0;
      end else if (load_first) begin
         data    <= DATA_BITS'(ser_in);
         bit_cnt <= CNT_W'(1);
      end else if (shift_en) begin
         data[bit_cnt[IDX_W-1:0]] <= ser_in;
         bit_cnt                  <= bit_cnt + CNT_W'(1);
      end else if (par_en) begin
         par_bit <= ser_in;
         bit_cnt <= '0;
      end
   end

   assign last_bit = (bit_cnt == CNT_W'(DATA_BITS - 1));
endmodule

// File: rtl/parity_serial_rx.sv
// Serial frame receiver that hands each byte to an external parity checker.
// Optional PARITY_RX_ERRCNT_EN adds a saturating err_cnt of failed frames.
module parity_serial_rx
   import parity_pkg::*;
#(
   parameter bit PARITY_ODD = 1'b0,
   parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
   input logic               clk,
   input logic               rst,
   parity_serial_rx_if.slave bus
`ifdef PARITY_RX_ERRCNT_EN
   ,
   output logic [7:0]        err_cnt
`endif
);
   localparam int TW = $clog2(TIMEOUT + 1);

   rx_state_t            state;
   logic [TW-1:0]        tcnt;
   logic                 sof_hit;
   logic                 load_first;
   logic                 shift_en;
   logic                 par_en;
   logic                 timed_out;
   logic [DATA_BITS-1:0] sh_data;
   logic                 par_bit;
   logic                 last_bit;

   assign sof_hit   = bus.ser_valid && bus.ser_sof;
   assign timed_out = (tcnt == TW'(TIMEOUT));

   always_comb begin
      load_first = 1'b0;
      shift_en   = 1'b0;
      par_en     = 1'b0;
      case (state)
         IDLE:  load_first = sof_hit;
         SHIFT: begin
            load_first = sof_hit;
            shift_en   = bus.ser_valid && !bus.ser_sof;
         end
         PBIT:  begin
            load_first = sof_hit;
            par_en     = bus.ser_valid && !bus.ser_sof;
         end
         default: ;
      endcase
   end

   parity_rx_shifter u_shifter (
      .clk        (clk),
      .rst        (rst),
      .ser_in     (bus.ser_in),
      .load_first (load_first),
      .shift_en   (shift_en),
      .par_en     (par_en),
      .data       (sh_data),
      .par_bit    (par_bit),
      .last_bit   (last_bit)
   );

   // Each wait state restarts tcnt; a stalled checker still yields a DONE strobe flagged as timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         tcnt           <= '0;
         bus.chk_data   <= '0;
         bus.chk_start  <= 1'b0;
         bus.rx_data    <= '0;
         bus.rx_valid   <= 1'b0;
         bus.rx_ok      <= 1'b0;
         bus.rx_timeout <= 1'b0;
         bus.overrun    <= 1'b0;
      end else begin
         bus.chk_start <= 1'b0;
         bus.rx_valid  <= 1'b0;
         case (state)
            IDLE: if (sof_hit) state <= SHIFT;
            SHIFT: begin
               if (sof_hit)
                  bus.overrun <= 1'b1;
               else if (bus.ser_valid && last_bit)
                  state <= PBIT;
            end
            PBIT: begin
               if (sof_hit) begin
                  bus.overrun <= 1'b1;
                  state       <= SHIFT;
               end else if (bus.ser_valid) begin
                  bus.chk_data  <= sh_data;
                  bus.chk_start <= 1'b1;
                  state         <= LAUNCH;
               end
            end
            LAUNCH: begin
               tcnt  <= '0;
               state <= WAIT_HI;
            end
            WAIT_HI, WAIT_LO: begin
               if ((state == WAIT_HI) && bus.chk_busy) begin
                  tcnt  <= '0;
                  state <= WAIT_LO;
               end else if ((state == WAIT_LO) && !bus.chk_busy) begin
                  state <= CHECK;
               end else if (timed_out) begin
                  bus.rx_data    <= sh_data;
                  bus.rx_ok      <= 1'b0;
                  bus.rx_timeout <= 1'b1;
                  bus.rx_valid   <= 1'b1;
                  state          <= DONE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            CHECK: begin
               bus.rx_data    <= sh_data;
               bus.rx_ok      <= (par_bit == (bus.chk_odd ^ PARITY_ODD)) && (bus.chk_odd ^ bus.chk_even);
               bus.rx_timeout <= 1'b0;
               bus.rx_valid   <= 1'b1;
               state          <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
         if (bus.ser_valid && (state inside {LAUNCH, WAIT_HI, WAIT_LO, CHECK, DONE}))
            bus.overrun <= 1'b1;
      end
   end

`ifdef PARITY_RX_ERRCNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         err_cnt <= 8'd0;
      else if ((state == DONE) && !bus.rx_ok && (err_cnt != 8'hFF))
         err_cnt <= err_cnt + 8'd1;
   end
`endif
endmodule
